// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and relock counter width.
package pll_seq_pkg;

   localparam int RELOCK_W = 8;

   typedef enum logic [1:0] {
      ST_PLL_RST   = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } pll_seq_state_e;

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous pll_locked into the reference clock domain.
module pll_lock_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses PLL reset, waits for a stable lock, then releases the system reset; re-sequences on lock loss.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int SYNC_STAGES         = 2,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 200000,
   parameter int CNT_W               = 20
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                pll_locked,
   input  logic                sw_reset_req,
   output logic                pll_rst,
   output logic                sys_reset_n,
   output logic                pll_ok,
   output logic [RELOCK_W-1:0] relock_cnt
);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

   logic                locked_s;
   pll_seq_state_e      state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RELOCK_W-1:0] relock_d;

   pll_lock_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (pll_locked),
      .sync_out (locked_s)
   );

   // Next-state is computed combinationally so the outputs can be registered from it.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      relock_d = relock_cnt;
      if (state_q == ST_RUN && !locked_s && relock_cnt != '1) begin
         relock_d = relock_cnt + 1'b1;
      end
      if (sw_reset_req) begin
         state_d = ST_PLL_RST;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_PLL_RST: begin
               if (cnt_q == RST_LAST) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_d = ST_PLL_RST;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_STABLE: begin
               if (!locked_s) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (!locked_s) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = ST_PLL_RST;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_PLL_RST;
         cnt_q       <= '0;
         relock_cnt  <= '0;
         pll_rst     <= 1'b1;
         sys_reset_n <= 1'b0;
         pll_ok      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         relock_cnt  <= relock_d;
         pll_rst     <= (state_d == ST_PLL_RST);
         sys_reset_n <= (state_d == ST_RUN);
         pll_ok      <= (state_d == ST_RUN);
      end
   end

endmodule
